// File: rtl/audio_sample_fifo.sv
// Stereo sample FIFO: packs left/right 24-bit words into 48-bit frames and
// presents them first-word-fall-through to the I2S master, with status counters.
module audio_sample_fifo #(
  parameter int DEPTH_LOG2   = 6,
  parameter int ALMOST_EMPTY = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [23:0]           in_data,
  input  logic                  in_left,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [47:0]           out_data,
  output logic                  out_valid,
  input  logic                  rd_ack,
  input  logic                  flush,
  input  logic                  clear_status,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  almost_empty,
  output logic [15:0]           underrun_count,
  output logic                  sync_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AE_LVL   = (DEPTH_LOG2+1)'(ALMOST_EMPTY);

  localparam logic [0:0] ST_IDLE      = 1'b0;
  localparam logic [0:0] ST_HAVE_LEFT = 1'b1;

  logic [47:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [23:0]           hold_q, hold_d;
  logic [0:0]            state_q, state_d;
  logic [15:0]           underrun_q, underrun_d;
  logic                  sync_err_q, sync_err_d;

  logic full, empty, left_pending, accept, commit, rd_do, underrun, bad_order;

  assign left_pending = (state_q == ST_HAVE_LEFT);
  assign full         = (level_q == FULL_LVL);
  assign empty        = (level_q == '0);

  // No bypass: a slot freed by rd_ack this cycle only helps next cycle.
  assign in_ready  = !flush && !(full && left_pending);
  assign accept    = in_valid && in_ready;
  assign commit    = accept && !in_left && left_pending;
  assign bad_order = accept && (in_left == left_pending);
  assign rd_do     = rd_ack && !empty && !flush;
  assign underrun  = rd_ack && empty && !flush;

  assign out_valid      = !empty;
  assign out_data       = out_valid ? mem_q[rd_ptr_q] : 48'd0;
  assign level          = level_q;
  assign almost_empty   = (level_q <= AE_LVL);
  assign underrun_count = underrun_q;
  assign sync_err       = sync_err_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    hold_d     = hold_q;
    state_d    = state_q;
    underrun_d = underrun_q;
    sync_err_d = sync_err_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      hold_d   = '0;
      state_d  = ST_IDLE;
    end else begin
      if (accept && in_left) begin
        hold_d  = in_data;
        state_d = ST_HAVE_LEFT;
      end else if (commit) begin
        state_d = ST_IDLE;
      end
      if (commit) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_do)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({commit, rd_do})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end

    // Clear wins over a same-cycle event, which is then lost.
    if (clear_status) begin
      underrun_d = '0;
      sync_err_d = 1'b0;
    end else begin
      if (underrun && underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
      if (bad_order) sync_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      hold_q     <= '0;
      state_q    <= ST_IDLE;
      underrun_q <= '0;
      sync_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      hold_q     <= hold_d;
      state_q    <= state_d;
      underrun_q <= underrun_d;
      sync_err_q <= sync_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && commit) mem_q[wr_ptr_q] <= {hold_q, in_data};
  end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Bench for audio_sample_fifo: vector table, directed corner sequences and
// randomized traffic checked against a queue-based frame model.
module tb_audio_sample_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] in_data;
  logic        in_left, in_valid, in_ready;
  logic [47:0] out_data;
  logic        out_valid, rd_ack, flush, clear_status;
  logic [6:0]  level;
  logic        almost_empty;
  logic [15:0] underrun_count;
  logic        sync_err;

  audio_sample_fifo #(.DEPTH_LOG2(6), .ALMOST_EMPTY(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_left(in_left),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .rd_ack(rd_ack), .flush(flush),
    .clear_status(clear_status), .level(level), .almost_empty(almost_empty),
    .underrun_count(underrun_count), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: frames as a queue, plus pack state and status.
  logic [47:0] m_q[$];
  logic        m_lp;
  logic [23:0] m_hold;
  logic [15:0] m_und;
  logic        m_serr;

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_left = 0; in_data = '0; rd_ack = 0; flush = 0; clear_status = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    m_q.delete(); m_lp = 0; m_hold = '0; m_und = '0; m_serr = 0;
  endtask

  // One clock: drive, check against model before the edge, update model, clock.
  task automatic cyc(input logic v, input logic l, input logic [23:0] d,
                     input logic ack, input logic fl, input logic cs);
    int    sz;
    logic  exp_rdy, acc, rd, und, bad;
    in_valid = v; in_left = l; in_data = d; rd_ack = ack; flush = fl; clear_status = cs;
    #1;
    sz      = m_q.size();
    exp_rdy = !fl && !(sz == 64 && m_lp);
    compare("in_ready", in_ready, exp_rdy);
    compare("out_valid", out_valid, sz != 0);
    compare("out_data", out_data, (sz != 0) ? m_q[0] : 48'd0);
    compare("level", level, sz);
    compare("almost_empty", almost_empty, sz <= 8);
    compare("underrun_count", underrun_count, m_und);
    compare("sync_err", sync_err, m_serr);

    acc = v && exp_rdy;
    rd  = ack && sz != 0 && !fl;
    und = ack && sz == 0 && !fl;
    bad = acc && (l == m_lp);
    if (fl) begin
      m_q.delete(); m_lp = 0; m_hold = '0;
    end else begin
      if (rd) void'(m_q.pop_front());
      if (acc && l) begin
        m_hold = d; m_lp = 1;
      end else if (acc && m_lp) begin
        m_q.push_back({m_hold, d}); m_lp = 0;
      end
    end
    if (cs) begin
      m_und = '0; m_serr = 0;
    end else begin
      if (und && m_und != 16'hFFFF) m_und++;
      if (bad) m_serr = 1;
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic push_frame(input logic [23:0] lw, input logic [23:0] rw);
    cyc(1, 1, lw, 0, 0, 0);
    cyc(1, 0, rw, 0, 0, 0);
  endtask

  typedef struct {
    logic        v, l;
    logic [23:0] d;
    logic        ack, fl, cs;
    logic [6:0]  e_level;
    logic        e_valid;
    logic [47:0] e_data;
    logic        e_sync;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{1,1,24'h123456,0,0,0, 7'd0,0,48'h0,0};
    tbl[1] = '{1,0,24'hABCDEF,0,0,0, 7'd1,1,48'h123456ABCDEF,0};
    tbl[2] = '{0,0,24'h0,1,0,0,       7'd0,0,48'h0,0};
    tbl[3] = '{1,0,24'h000111,0,0,0,  7'd0,0,48'h0,1};
    tbl[4] = '{0,0,24'h0,0,0,1,       7'd0,0,48'h0,0};
    tbl[5] = '{1,1,24'h000001,0,0,0,  7'd0,0,48'h0,0};
    tbl[6] = '{1,1,24'h000002,0,0,0,  7'd0,0,48'h0,1};
    tbl[7] = '{1,0,24'h000003,0,0,0,  7'd1,1,48'h000002000003,1};
    tbl[8] = '{0,0,24'h0,1,0,1,       7'd0,0,48'h0,0};

    do_reset();
    #1;
    compare("rst_level", level, 0);
    compare("rst_out_valid", out_valid, 0);
    compare("rst_out_data", out_data, 0);
    compare("rst_in_ready", in_ready, 1);
    compare("rst_almost_empty", almost_empty, 1);
    compare("rst_underrun", underrun_count, 0);
    compare("rst_sync_err", sync_err, 0);

    // Vector table
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].ack, tbl[i].fl, tbl[i].cs);
      compare("tbl_level", level, tbl[i].e_level);
      compare("tbl_out_valid", out_valid, tbl[i].e_valid);
      compare("tbl_out_data", out_data, tbl[i].e_data);
      compare("tbl_sync_err", sync_err, tbl[i].e_sync);
    end

    // Full, back-pressure on the pending right word, then drain across the wrap
    do_reset();
    for (int i = 0; i < 64; i++) push_frame(24'h100000 + 24'(i), 24'h200000 + 24'(i));
    compare("full_level", level, 64);
    cyc(1, 1, 24'hAAAAAA, 0, 0, 0);
    in_valid = 1; in_left = 0; in_data = 24'hBBBBBB; #1;
    compare("full_in_ready_blocked", in_ready, 0);
    cyc(1, 0, 24'hBBBBBB, 1, 0, 0);
    compare("full_after_ack_level", level, 63);
    cyc(1, 0, 24'hBBBBBB, 0, 0, 0);
    compare("full_refill_level", level, 64);
    for (int i = 0; i < 64; i++) cyc(0, 0, 0, 1, 0, 0);
    compare("drained_level", level, 0);

    // Underruns: counting, clear, saturation
    do_reset();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
    compare("underrun_3", underrun_count, 3);
    compare("underrun_level", level, 0);
    cyc(0, 0, 0, 0, 0, 1);
    compare("underrun_cleared", underrun_count, 0);
    for (int i = 0; i < 70000; i++) cyc(0, 0, 0, 1, 0, 0);
    compare("underrun_sat", underrun_count, 16'hFFFF);
    push_frame(24'h000AAA, 24'h000BBB);
    compare("post_underrun_data", out_data, 48'h000AAA000BBB);

    // Flush with 10 frames and a pending left word
    do_reset();
    for (int i = 0; i < 10; i++) push_frame(24'(i), 24'(i + 100));
    cyc(1, 1, 24'h777777, 0, 0, 0);
    cyc(1, 0, 24'h888888, 1, 1, 0);
    compare("flush_level", level, 0);
    compare("flush_out_valid", out_valid, 0);
    compare("flush_sync_kept", sync_err, 0);
    cyc(1, 0, 24'h999999, 0, 0, 0);
    compare("flush_r_dropped_level", level, 0);
    compare("flush_r_sync_err", sync_err, 1);

    // Streaming at level 5: commit and read on the same edge
    do_reset();
    for (int i = 0; i < 5; i++) push_frame(24'h300000 + 24'(i), 24'h400000 + 24'(i));
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 24'h500000 + 24'(i), 0, 0, 0);
      cyc(1, 0, 24'h600000 + 24'(i), 1, 0, 0);
      compare("stream_level", level, 5);
      compare("stream_almost_empty", almost_empty, 1);
    end
    compare("stream_head", out_data, {24'h500000 + 24'd15, 24'h600000 + 24'd15});

    // Randomized traffic in phases biased toward filling or draining
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int   ph;
      logic v, l, a, f, c;
      ph = (i / 500) % 2;
      v  = ($urandom_range(0, 9) < (ph == 0 ? 8 : 4));
      l  = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 1) : !m_lp;
      a  = ($urandom_range(0, 9) < (ph == 0 ? 2 : 6));
      f  = ($urandom_range(0, 199) == 0);
      c  = ($urandom_range(0, 63) == 0);
      cyc(v, l, 24'($urandom), a, f, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/audio_sample_fifo.md
Name: audio_sample_fifo

Overview:
- Stereo sample buffer that sits directly upstream of the I2S master.
- Accepts 24-bit mono words from the bus or DMA side, tagged left or right.
- Packs each left/right pair into one 48-bit frame {left[23:0], right[23:0]} and stores it in a circular buffer.
- Presents frames first-word-fall-through on a valid/ack interface. The ack is the I2S master's one-cycle read pulse.
- Reports fill level, almost-empty, underrun count and channel-sync errors to a status register block.

Parameters:
- DEPTH_LOG2, 6, log2 of frame capacity (64 frames).
- ALMOST_EMPTY, 8, almost_empty asserts when level <= this value.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- in_data  input  24  sample word.
- in_left  input  1  1 = left-channel word, 0 = right-channel word.
- in_valid  input  1  in_data/in_left valid.
- in_ready  output  1  word accepted when in_valid && in_ready.
- out_data  output  48  head frame {left, right}.
- out_valid  output  1  FIFO non-empty.
- rd_ack  input  1  one-cycle pulse; consumes the head frame.
- flush  input  1  synchronous clear of buffer contents.
- clear_status  input  1  clears underrun_count and sync_err.
- level  output  DEPTH_LOG2+1  number of stored frames.
- almost_empty  output  1  level <= ALMOST_EMPTY.
- underrun_count  output  16  saturating count of rd_ack while empty.
- sync_err  output  1  sticky channel-ordering error.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high, and takes priority over everything else.
- Reset values:
  - Pointers 0, level 0, out_valid 0, out_data 0, in_ready 1, underrun_count 0, sync_err 0.
  - Holding register 0, left_pending 0.
  - almost_empty 1.
- Storage: 2^DEPTH_LOG2 x 48-bit array. Write and read pointers are DEPTH_LOG2 bits and wrap modulo depth. Full = (level == 2^DEPTH_LOG2). Empty = (level == 0).
- Pack state machine, states IDLE (left_pending=0) and HAVE_LEFT (left_pending=1):
  - IDLE + accepted left word: latch into holding register, go to HAVE_LEFT.
  - IDLE + accepted right word: drop the word, set sync_err, stay in IDLE.
  - HAVE_LEFT + accepted right word: commit {holding, in_data} at the write pointer, increment the write pointer, go to IDLE.
  - HAVE_LEFT + accepted left word: overwrite the holding register, set sync_err, stay in HAVE_LEFT.
- in_ready = !(full && left_pending). Combinational, with no bypass. A frame freed by rd_ack in the same cycle does not enable the commit; it proceeds next cycle.
- Read side:
  - out_valid = !empty.
  - out_data = array[rd_ptr] when out_valid, else 0.
  - A committed frame is visible on out_data/out_valid the cycle after the commit edge (latency 1).
- rd_ack && out_valid: increment the read pointer. out_data shows the next frame the following cycle.
- rd_ack && !out_valid: no pointer change; increment underrun_count, saturating at 16'hFFFF. The I2S master outputs zeros in this case.
- Same-cycle commit and read: level unchanged, both pointers advance.
- level updates on the same edge as pointers. almost_empty is derived combinationally from level.
- flush:
  - Clears pointers, level, holding register and left_pending on the next edge.
  - Any rd_ack or input word in that cycle is ignored, and in_ready is forced to 0 during flush.
  - underrun_count and sync_err are not affected.
- clear_status: clears underrun_count and sync_err. If an underrun or sync error occurs in the same cycle, the clear wins and the event is lost.
- sync_err is sticky until clear_status or rst.

Test Plan:
- Reset, then write L=0x123456, R=0xABCDEF -> out_valid=1 one cycle after the R accept; out_data=0x123456ABCDEF; level=1; almost_empty=1.
- Write 64 frames with no rd_ack -> level=64. Next L accepted (in_ready=1); then in_ready=0 while R is presented. Pulse rd_ack -> level=63; R accepted the following cycle -> level=64. Read out all frames in write order, including across the pointer wrap.
- With the FIFO empty, pulse rd_ack 3 times -> underrun_count=3, level=0, pointers unchanged. Pulse clear_status -> underrun_count=0. Force 70000 underruns -> underrun_count holds 0xFFFF.
- Send R with no preceding L -> sync_err=1, no frame stored. Then send L,L,R (0x1,0x2,0x3) -> one frame 0x000002000003 stored, sync_err still 1.
- Hold 10 frames plus a pending L, assert flush -> next cycle level=0, out_valid=0, left_pending=0. A following R is dropped and sets sync_err.
- Streaming at level=5: commit and rd_ack in the same cycle for 20 cycles -> level stays 5; output sequence matches input sequence. almost_empty=1 throughout (5 <= 8).
